// File: rtl/alu_reservation_station.sv
// alu_reservation_station
// Tomasulo reservation station for the integer ALU. Holds dispatched ALU /
// branch-compare ops until both operands are known (either supplied at
// dispatch or captured from the common data bus), then issues the oldest-slot
// (lowest index) ready op to the ALU, one per cycle.
//
// Handshake: there is no ready/valid back-pressure towards the ALU; an issue
// is signalled by alu_des != 0 (tag 0 means "no op"). Towards the decoder,
// a dispatch is taken on a clock edge when in_valid && !full && !pause &&
// !flush; full is purely a function of occupancy.
//
// Optional feature: define ALU_RS_BYPASS_EN to let a ready dispatch skip the
// entry array and go straight to the alu_* registers when no entry is READY.
module alu_reservation_station #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_v1,
  input  logic [DATA_W-1:0] in_v2,
  input  logic [TAG_W-1:0]  in_q1,
  input  logic [TAG_W-1:0]  in_q2,
  input  logic [TAG_W-1:0]  in_des,
  input  logic              in_is_branch,
  output logic              full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic [DATA_W-1:0] alu_value_1,
  output logic [DATA_W-1:0] alu_value_2,
  output logic [OP_W-1:0]   alu_op,
  output logic [TAG_W-1:0]  alu_des,
  output logic              alu_is_branch
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Per-entry lifecycle; the state field lives inside each entry struct so
  // the whole station (state included) is visible as one array.
  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } ent_state_e;

  typedef struct packed {
    ent_state_e          state;
    logic [OP_W-1:0]     op;
    logic [DATA_W-1:0]   v1;
    logic [DATA_W-1:0]   v2;
    logic [TAG_W-1:0]    q1;
    logic [TAG_W-1:0]    q2;
    logic [TAG_W-1:0]    des;
    logic                is_branch;
  } entry_t;

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];

  logic [DATA_W-1:0] alu_v1_q, alu_v1_d;
  logic [DATA_W-1:0] alu_v2_q, alu_v2_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [TAG_W-1:0]  alu_des_q, alu_des_d;
  logic              alu_br_q, alu_br_d;

  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic              rdy_found;
  logic [IDX_W-1:0]  rdy_idx;

  logic              cdb_hit1;
  logic              cdb_hit2;
  logic [DATA_W-1:0] fwd_v1;
  logic [DATA_W-1:0] fwd_v2;
  logic [TAG_W-1:0]  fwd_q1;
  logic [TAG_W-1:0]  fwd_q2;
  logic              disp_ready;
  logic              dispatch_ok;
  logic              bypass;

  // Lowest-index FREE and READY slots, both taken from the pre-edge state.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    rdy_found  = 1'b0;
    rdy_idx    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].state == ST_FREE) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ent_q[i].state == ST_READY) begin
        rdy_found = 1'b1;
        rdy_idx   = IDX_W'(i);
      end
    end
  end

  assign full = !free_found;

  // Same-edge forwarding of a CDB broadcast into the op being dispatched.
  always_comb begin
    cdb_hit1   = cdb_valid && (in_q1 != '0) && (cdb_tag == in_q1);
    cdb_hit2   = cdb_valid && (in_q2 != '0) && (cdb_tag == in_q2);
    fwd_v1     = cdb_hit1 ? cdb_value : in_v1;
    fwd_v2     = cdb_hit2 ? cdb_value : in_v2;
    fwd_q1     = cdb_hit1 ? '0 : in_q1;
    fwd_q2     = cdb_hit2 ? '0 : in_q2;
    disp_ready = (fwd_q1 == '0) && (fwd_q2 == '0);
  end

  assign dispatch_ok = in_valid && !full && !pause && !flush;

`ifdef ALU_RS_BYPASS_EN
  // A ready dispatch with nothing else waiting to issue goes straight out.
  assign bypass = dispatch_ok && disp_ready && !rdy_found;
`else
  assign bypass = 1'b0;
`endif

  // Next-state: flush, then wakeup / issue / dispatch when not paused.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
    end
    alu_v1_d  = alu_v1_q;
    alu_v2_d  = alu_v2_q;
    alu_op_d  = alu_op_q;
    alu_des_d = alu_des_q;
    alu_br_d  = alu_br_q;

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].state = ST_FREE;
      end
      alu_op_d  = '1;
      alu_des_d = '0;
      alu_br_d  = 1'b0;
    end else if (!pause) begin
      // Wakeup: any occupied entry waiting on the broadcast tag captures it.
      for (int i = 0; i < DEPTH; i++) begin
        if ((ent_q[i].state != ST_FREE) && cdb_valid && (cdb_tag != '0)) begin
          if (ent_q[i].q1 == cdb_tag) begin
            ent_d[i].v1 = cdb_value;
            ent_d[i].q1 = '0;
          end
          if (ent_q[i].q2 == cdb_tag) begin
            ent_d[i].v2 = cdb_value;
            ent_d[i].q2 = '0;
          end
          if ((ent_q[i].state == ST_WAIT) && (ent_d[i].q1 == '0) &&
              (ent_d[i].q2 == '0)) begin
            ent_d[i].state = ST_READY;
          end
        end
      end

      // Issue: the pre-edge READY entry leaves; otherwise the ALU sees idle.
      if (rdy_found) begin
        alu_v1_d  = ent_q[rdy_idx].v1;
        alu_v2_d  = ent_q[rdy_idx].v2;
        alu_op_d  = ent_q[rdy_idx].op;
        alu_des_d = ent_q[rdy_idx].des;
        alu_br_d  = ent_q[rdy_idx].is_branch;
        ent_d[rdy_idx].state = ST_FREE;
      end else begin
        alu_op_d  = '1;
        alu_des_d = '0;
        alu_br_d  = 1'b0;
      end

      // Dispatch: free_idx was FREE before the edge, so it never collides
      // with the entry being issued; that one is reusable next cycle only.
      if (dispatch_ok) begin
        if (bypass) begin
          alu_v1_d  = fwd_v1;
          alu_v2_d  = fwd_v2;
          alu_op_d  = in_op;
          alu_des_d = in_des;
          alu_br_d  = in_is_branch;
        end else begin
          ent_d[free_idx].state     = disp_ready ? ST_READY : ST_WAIT;
          ent_d[free_idx].op        = in_op;
          ent_d[free_idx].v1        = fwd_v1;
          ent_d[free_idx].v2        = fwd_v2;
          ent_d[free_idx].q1        = fwd_q1;
          ent_d[free_idx].q2        = fwd_q2;
          ent_d[free_idx].des       = in_des;
          ent_d[free_idx].is_branch = in_is_branch;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i]       <= '0;
        ent_q[i].state <= ST_FREE;
      end
      alu_v1_q  <= '0;
      alu_v2_q  <= '0;
      alu_op_q  <= '1;
      alu_des_q <= '0;
      alu_br_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      alu_v1_q  <= alu_v1_d;
      alu_v2_q  <= alu_v2_d;
      alu_op_q  <= alu_op_d;
      alu_des_q <= alu_des_d;
      alu_br_q  <= alu_br_d;
    end
  end

  assign alu_value_1   = alu_v1_q;
  assign alu_value_2   = alu_v2_q;
  assign alu_op        = alu_op_q;
  assign alu_des       = alu_des_q;
  assign alu_is_branch = alu_br_q;

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Reservation station feeding the integer ALU in the Tomasulo back end; the issuing end of the ALU operand/op/destination-tag interface.
- Accepts dispatched ALU/branch ops from the decoder with operand values or ROB producer tags.
- Snoops the common data bus (CDB) to wake up waiting operands, then issues one ready op per cycle to the ALU.
- Tag 0 means "no tag / operand valid", consistent with the ALU treating destination 0 as no result.

Parameters:
- DEPTH, 4, number of station entries (power of two, 2..8)
- TAG_W, 3, ROB tag width; tag 0 reserved as "none"
- DATA_W, 32, operand width
- OP_W, 5, ALU opcode width

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, synchronous, active-low
- pause  input  1  global stall: freeze all state and outputs
- flush  input  1  mispredict flush: drop all entries
- in_valid  input  1  dispatch request this cycle
- in_op  input  OP_W  ALU opcode
- in_v1, in_v2  input  DATA_W  operand values (meaningful when matching q is 0)
- in_q1, in_q2  input  TAG_W  producer tags; 0 = value already valid
- in_des  input  TAG_W  destination ROB tag (non-zero)
- in_is_branch  input  1  op is a conditional branch compare
- full  output  1  no free entry; dispatch rejected this cycle
- cdb_valid  input  1  broadcast valid
- cdb_tag  input  TAG_W  broadcasting ROB tag
- cdb_value  input  DATA_W  broadcast value
- alu_value_1, alu_value_2  output  DATA_W  issued operands
- alu_op  output  OP_W  issued opcode; 5'b11111 when idle
- alu_des  output  TAG_W  issued destination; 0 when idle
- alu_is_branch  output  1  issued branch flag; 0 when idle

Behaviour:
- Reset (rst==0 at posedge): all entries FREE; alu_value_1/2=0, alu_op=5'b11111, alu_des=0, alu_is_branch=0. Takes priority over pause and flush.
- Entry states:
  - FREE -> WAIT on dispatch with any operand tag non-zero after forwarding.
  - FREE -> READY on dispatch with both tags zero after forwarding.
  - WAIT -> READY when the last pending tag is captured from the CDB.
  - READY -> FREE when issued.
- full: combinational, equals (all entries non-FREE); not affected by same-cycle issue.
- Dispatch: accepted when in_valid && !full && !pause && !flush. Allocates the lowest-index FREE entry.
- Dispatch forwarding: if cdb_valid and cdb_tag==in_qN (in_qN != 0), store cdb_value and set qN=0 in the same edge.
- Wakeup: every non-FREE entry with qN==cdb_tag (non-zero, cdb_valid) captures cdb_value and clears qN; both operands may match at once. cdb_tag 0 never matches.
- Issue:
  - At each posedge, select the lowest-index entry that is READY in the pre-edge state.
  - Drive its fields to the alu_* registers and free the entry.
  - If none is READY, drive idle values (op 5'b11111, des 0, is_branch 0; values hold their previous contents).
- Latency:
  - Dispatch with ready operands at edge N -> alu_* valid after edge N+1.
  - CDB wakeup at edge N -> issue after edge N+1.
  - Entries written at an edge are not issued at that same edge.
- Simultaneous issue and dispatch: both occur; the freed slot is reusable from the next cycle only.
- pause==1: no dispatch, no wakeup capture, no issue; all entries and alu_* outputs hold. The producer must hold its CDB broadcast across pause.
- flush==1 (rst high): all entries FREE; alu_* forced to idle values at that edge; in_valid ignored. pause does not block flush.
- Reset or flush mid-operation discards waiting and ready entries without issuing them.

Optional Feature:
- Macro ALU_RS_BYPASS_EN.
- Defined: an accepted dispatch that is ready after forwarding, arriving while no entry is READY, is written directly to the alu_* registers at that edge and allocates no entry. Latency is 1 edge; full is still checked first.
- Undefined: every dispatch goes through an entry (latency 2 edges).

Test Plan:
- Reset: hold rst=0 two cycles -> alu_op=5'b11111, alu_des=0, full=0. Then dispatch ADD(op 0) v1=5, v2=7, q=0, des=3 -> after edge N+1: alu_op=0, alu_value_1=5, alu_value_2=7, alu_des=3 (edge N with ALU_RS_BYPASS_EN).
- Wakeup: dispatch SUB(op 8) q1=2, v2=1, des=4 -> stays idle. CDB tag=2 value=10 -> next edge alu_op=8, alu_value_1=10, alu_des=4.
- Forwarding: dispatch with q1=5 while cdb_valid, cdb_tag=5, value=0xDEAD -> entry READY, issues with alu_value_1=0xDEAD.
- Full: 4 dispatches all with q1=6 -> full=1. A 5th dispatch is ignored. CDB tag 6 -> entries issue in index order 0,1,2,3 on consecutive cycles; full drops after the first issue.
- Pause: ready entry pending, pause=1 for 3 cycles -> alu_* unchanged and in_valid ignored. On release, issue occurs on the next edge.
- Flush: 3 WAIT entries, flush=1 -> full=0, alu_des=0. A later CDB on their tags issues nothing.
